// File: rtl/pong_pkg.sv
//------------------------------------------------------------------------------
// pong_pkg : shared screen geometry and paddle FSM state encoding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pong_pkg;
   localparam int SCREEN_HEIGHT = 480;
   localparam int PADDLE_HEIGHT = 80;
   localparam int Y_MAX         = SCREEN_HEIGHT - PADDLE_HEIGHT;
   localparam int Y_CENTRE      = SCREEN_HEIGHT / 2 - PADDLE_HEIGHT / 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MOVE_UP = 2'd1,
      MOVE_DN = 2'd2
   } state_t;
endpackage

`default_nettype wire

// File: rtl/paddle_channel.sv
//------------------------------------------------------------------------------
// paddle_channel : one paddle - direction FSM, speed ramp, clamped step, auto-track
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module paddle_channel
   import pong_pkg::*;
#(
   parameter int Y_WIDTH      = 16,
   parameter int SCR_HEIGHT   = 480,
   parameter int PAD_HEIGHT   = 80,
   parameter int MAX_SPEED    = 8,
   parameter int ACCEL_DIV    = 4,
   parameter int DEADBAND     = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               up,
   input  logic               down,
   input  logic               auto_mode,
   input  logic [Y_WIDTH-1:0] ball_y,
   output logic [Y_WIDTH-1:0] paddle_y,
   output logic               moving,
   output logic               at_max,
   output logic               at_min
);
   localparam int YW1    = Y_WIDTH + 1;
   localparam int SPD_W  = $clog2(MAX_SPEED + 1);
   localparam int HOLD_W = (ACCEL_DIV > 1) ? $clog2(ACCEL_DIV) : 1;

   localparam logic [YW1-1:0]    C_YMAX   = YW1'(SCR_HEIGHT - PAD_HEIGHT);
   localparam logic [YW1-1:0]    C_CENTRE = YW1'(SCR_HEIGHT / 2 - PAD_HEIGHT / 2);
   localparam logic [YW1-1:0]    C_HALF   = YW1'(PAD_HEIGHT / 2);
   localparam logic [YW1-1:0]    C_DB     = YW1'(DEADBAND);
   localparam logic [SPD_W-1:0]  C_SMAX   = SPD_W'(MAX_SPEED);
   localparam logic [HOLD_W-1:0] C_HLAST  = HOLD_W'(ACCEL_DIV - 1);

   state_t            state, state_nx, req;
   logic [SPD_W-1:0]  speed, speed_nx;
   logic [HOLD_W-1:0] hold, hold_nx;
   logic [YW1-1:0]    y_ext, ball_ext, target, diff, step, sum, y_nx;

   assign y_ext    = {1'b0, paddle_y};
   assign ball_ext = {1'b0, ball_y};

   // Auto-track target: ball centre minus half paddle, saturated into [0, Y_MAX]
   always_comb begin
      target = '0;
      if (ball_ext >= C_HALF) begin
         target = ball_ext - C_HALF;
         if (target > C_YMAX) target = C_YMAX;
      end
   end

   always_comb begin
      req = IDLE;
      if (auto_mode) begin
         if (target > y_ext + C_DB)      req = MOVE_UP;
         else if (target + C_DB < y_ext) req = MOVE_DN;
      end else if (up && !down) begin
         req = MOVE_UP;
      end else if (down && !up) begin
         req = MOVE_DN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         speed    <= '0;
         hold     <= '0;
         paddle_y <= C_CENTRE[Y_WIDTH-1:0];
         moving   <= 1'b0;
         at_max   <= 1'b0;
         at_min   <= 1'b0;
      end else begin
         state    <= state_nx;
         speed    <= speed_nx;
         hold     <= hold_nx;
         paddle_y <= y_nx[Y_WIDTH-1:0];
         moving   <= (state_nx != IDLE);
         at_max   <= (y_nx == C_YMAX);
         at_min   <= (y_nx == '0);
      end
   end

   always_comb begin
      state_nx = state;
      speed_nx = speed;
      hold_nx  = hold;
      if (frame_tick) begin
         if (req == IDLE) begin
            state_nx = IDLE;
            speed_nx = '0;
            hold_nx  = '0;
         end else if (req != state) begin
            state_nx = req;
            speed_nx = SPD_W'(1);
            hold_nx  = '0;
         end else if (hold == C_HLAST) begin
            speed_nx = (speed >= C_SMAX) ? C_SMAX : speed + SPD_W'(1);
            hold_nx  = '0;
         end else begin
            hold_nx  = hold + HOLD_W'(1);
         end
      end
   end

   // Step uses the post-update speed; auto mode never steps past its target
   always_comb begin
      diff = (target > y_ext) ? target - y_ext : y_ext - target;
      step = YW1'(speed_nx);
      if (auto_mode && diff < step) step = diff;
      sum  = y_ext + step;
      y_nx = y_ext;
      if (frame_tick) begin
         case (state_nx)
            MOVE_UP: y_nx = (sum > C_YMAX) ? C_YMAX : sum;
            MOVE_DN: y_nx = (y_ext >= step) ? y_ext - step : '0;
            default: y_nx = y_ext;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: rtl/paddle_motion_array.sv
//------------------------------------------------------------------------------
// paddle_motion_array : NUM_PADDLES independent frame-paced paddle channels
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module paddle_motion_array
   import pong_pkg::*;
#(
   parameter int NUM_PADDLES   = 2,
   parameter int Y_WIDTH       = 16,
   parameter int SCREEN_HEIGHT = pong_pkg::SCREEN_HEIGHT,
   parameter int PADDLE_HEIGHT = pong_pkg::PADDLE_HEIGHT,
   parameter int MAX_SPEED     = 8,
   parameter int ACCEL_DIV     = 4,
   parameter int DEADBAND      = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           frame_tick,
   input  logic [NUM_PADDLES-1:0]         up,
   input  logic [NUM_PADDLES-1:0]         down,
   input  logic [NUM_PADDLES-1:0]         auto_mode,
   input  logic [Y_WIDTH-1:0]             ball_y,
   output logic [NUM_PADDLES*Y_WIDTH-1:0] paddle_y,
   output logic [NUM_PADDLES-1:0]         moving,
   output logic [NUM_PADDLES-1:0]         at_max,
   output logic [NUM_PADDLES-1:0]         at_min
);
   generate
      for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_chan
         paddle_channel #(
            .Y_WIDTH    (Y_WIDTH),
            .SCR_HEIGHT (SCREEN_HEIGHT),
            .PAD_HEIGHT (PADDLE_HEIGHT),
            .MAX_SPEED  (MAX_SPEED),
            .ACCEL_DIV  (ACCEL_DIV),
            .DEADBAND   (DEADBAND)
         ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .frame_tick (frame_tick),
            .up         (up[i]),
            .down       (down[i]),
            .auto_mode  (auto_mode[i]),
            .ball_y     (ball_y),
            .paddle_y   (paddle_y[i*Y_WIDTH +: Y_WIDTH]),
            .moving     (moving[i]),
            .at_max     (at_max[i]),
            .at_min     (at_min[i])
         );
      end
   endgenerate
endmodule

`default_nettype wire

// File: tb/tb_paddle_motion_array.sv
//------------------------------------------------------------------------------
// tb_paddle_motion_array : directed self-checking bench for paddle_motion_array
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_paddle_motion_array;
   localparam int NP = 2;
   localparam int YW = 16;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             frame_tick = 1'b0;
   logic [NP-1:0]    up = '0;
   logic [NP-1:0]    down = '0;
   logic [NP-1:0]    auto_mode = '0;
   logic [YW-1:0]    ball_y = '0;
   logic [NP*YW-1:0] paddle_y;
   logic [NP-1:0]    moving;
   logic [NP-1:0]    at_max;
   logic [NP-1:0]    at_min;

   int checks = 0;
   int errors = 0;

   paddle_motion_array #(.NUM_PADDLES(NP), .Y_WIDTH(YW)) dut (
      .clock      (clock),
      .reset      (reset),
      .frame_tick (frame_tick),
      .up         (up),
      .down       (down),
      .auto_mode  (auto_mode),
      .ball_y     (ball_y),
      .paddle_y   (paddle_y),
      .moving     (moving),
      .at_max     (at_max),
      .at_min     (at_min)
   );

   always #5 clock = ~clock;

   function automatic int py(input int i);
      return int'(paddle_y[i*YW +: YW]);
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock) frame_tick = 1'b1;
         @(negedge clock) frame_tick = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; up = '0; down = '0; auto_mode = '0;
      @(negedge clock) reset = 1'b0;
   endtask

   initial begin
      // 1: reset, input toggling without ticks moves nothing
      do_reset();
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         up = NP'(k); down = NP'(~k);
      end
      @(negedge clock);
      check("rst_y0", py(0), 200);
      check("rst_y1", py(1), 200);
      check("rst_moving", int'(moving), 0);
      check("rst_at_max", int'(at_max), 0);
      check("rst_at_min", int'(at_min), 0);

      // 2: ramp on paddle 0, paddle 1 untouched
      up = 2'b01; down = '0;
      ticks(1); check("ramp_t1", py(0), 201);
      ticks(3); check("ramp_t4", py(0), 204);
      ticks(1); check("ramp_t5", py(0), 206);
      ticks(1); check("ramp_t6", py(0), 208);
      check("ramp_moving", int'(moving), 1);
      check("ramp_other", py(1), 200);

      // 3: conflict rejection, then speed restarts at 1
      down = 2'b01;
      ticks(1);
      check("conflict_y", py(0), 208);
      check("conflict_moving", int'(moving), 0);
      down = '0;
      ticks(1);
      check("restart_y", py(0), 209);

      // 4: upper clamp without overshoot
      do_reset();
      up = 2'b01;
      ticks(38); check("up38", py(0), 392);
      up = '0;  ticks(1);
      up = 2'b01; ticks(1); check("up_single", py(0), 393);
      up = '0;  ticks(1);
      up = 2'b01;
      ticks(5); check("near_max", py(0), 399);
      check("near_max_flag", int'(at_max), 0);
      ticks(1); check("clamp_max", py(0), 400);
      check("clamp_max_flag", int'(at_max[0]), 1);
      ticks(2); check("hold_max", py(0), 400);
      check("hold_max_moving", int'(moving[0]), 1);

      // lower clamp on paddle 1
      do_reset();
      down = 2'b10;
      ticks(38); check("dn38", py(1), 8);
      ticks(1);  check("clamp_min", py(1), 0);
      check("clamp_min_flag", int'(at_min), 2);
      ticks(1);  check("hold_min", py(1), 0);
      check("hold_min_moving", int'(moving), 2);
      check("dn_other", py(0), 200);

      // 5: auto-track with deadband; manual request ignored in auto mode
      do_reset();
      auto_mode = 2'b10; down = 2'b10; ball_y = 16'd242;
      ticks(1);
      check("deadband_y", py(1), 200);
      check("deadband_moving", int'(moving), 0);
      ball_y = 16'd300;
      ticks(5);  check("auto_t5", py(1), 206);
      ticks(15); check("auto_t20", py(1), 260);
      ticks(1);  check("auto_settle", py(1), 260);
      check("auto_settle_moving", int'(moving), 0);
      check("auto_other", py(0), 200);

      // 6: reset mid-ramp wins over a coincident tick
      do_reset();
      up = 2'b01;
      ticks(17); check("pre_reset", py(0), 245);
      @(negedge clock);
      reset = 1'b1; frame_tick = 1'b1;
      @(negedge clock);
      reset = 1'b0; frame_tick = 1'b0;
      check("mid_reset_y", py(0), 200);
      check("mid_reset_moving", int'(moving), 0);
      ticks(1); check("post_reset_step", py(0), 201);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
